fila_circular: RTL and testbench

//  Parametrised circular-buffer FIFO queue; successor of the fixed 8x8 shift-register queue.

---
 rtl/fila_pkg.sv | 20 ++
 rtl/fila_circular_if.sv | 32 +++
 rtl/fila_ptr.sv | 29 ++
 rtl/fila_circular.sv | 126 ++++++++++++
 tb/tb_fila_circular.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fila_pkg.sv
// Shared definitions for the circular queue family: default geometry and the
// request classification used when resolving enqueue/dequeue in one cycle.
package fila_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_AF_LEVEL = 6;

  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_ENQ  = 2'b01,
    REQ_DEQ  = 2'b10,
    REQ_BOTH = 2'b11
  } req_e;

  function automatic req_e decode_req(input logic enq, input logic deq);
    return req_e'({deq, enq});
  endfunction

endpackage

// File: rtl/fila_circular_if.sv
// Data/control bundle between a producer-consumer pair and the circular queue.
interface fila_circular_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int LEN_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] data_in;
  logic              enqueue_in;
  logic              dequeue_in;
  logic              clear_err_in;
  logic [DATA_W-1:0] data_out;
  logic [LEN_W-1:0]  len_out;
  logic              full_out;
  logic              empty_out;
  logic              almost_full_out;
  logic              overflow_out;
  logic              underflow_out;

  modport master (
    output data_in, enqueue_in, dequeue_in, clear_err_in,
    input  data_out, len_out, full_out, empty_out, almost_full_out,
           overflow_out, underflow_out
  );

  modport slave (
    input  data_in, enqueue_in, dequeue_in, clear_err_in,
    output data_out, len_out, full_out, empty_out, almost_full_out,
           overflow_out, underflow_out
  );

endinterface

// File: rtl/fila_ptr.sv
// Queue pointer: advances by one when enabled and wraps from DEPTH-1 to 0,
// so non-power-of-two depths work without modulo arithmetic.
module fila_ptr #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_10KHz,
  input  logic             reset,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // NOTE: sequential state is always updated with <= so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LEAST_GUARD(LAST)) ? '0 : ptr + PTR_W'(1);
    end
  end

  function automatic logic [PTR_W-1:0] LEAST_GUARD(input logic [PTR_W-1:0] v);
    return v;
  endfunction

endmodule

// File: rtl/fila_circular.sv
// Parametrised circular-buffer FIFO with occupancy flags and sticky
// overflow/underflow errors; head/tail pointers replace data shifting.
module fila_circular
  import fila_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL
) (
  input logic           clk_10KHz,
  input logic           reset,
  fila_circular_if.slave bus
);

  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [LEN_W-1:0]             len;
  logic [DATA_W-1:0]            data_q;
  logic                         overflow_q;
  logic                         underflow_q;

  req_e req;
  logic full;
  logic empty;
  logic do_enq;
  logic do_deq;
  logic ovf_evt;
  logic udf_evt;

  assign full  = (len == LEN_W'(DEPTH));
  assign empty = (len == '0);

  // Resolution uses the pre-edge count; a full queue still accepts enq+deq
  // because the dequeue frees the slot being written.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    do_enq  = 1'b0;
    do_deq  = 1'b0;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    req     = decode_req(bus.enqueue_in, bus.dequeue_in);
    case (req)
      REQ_ENQ: begin
        if (full) ovf_evt = 1'b1;
        else      do_enq  = 1'b1;
      end
      REQ_DEQ: begin
        if (empty) udf_evt = 1'b1;
        else       do_deq  = 1'b1;
      end
      REQ_BOTH: begin
        do_enq = 1'b1;
        if (empty) udf_evt = 1'b1;
        else       do_deq  = 1'b1;
      end
      default: ;
    endcase
  end

  fila_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .en        (do_deq),
    .ptr       (head)
  );

  fila_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .en        (do_enq),
    .ptr       (tail)
  );

  // NOTE: storage has no reset; stale entries are unreachable because the
  // count and pointers are reset, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk_10KHz) begin
    if (do_enq && !reset) begin
      mem[tail] <= bus.data_in;
    end
  end

  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      len <= '0;
    end else begin
      case ({do_enq, do_deq})
        2'b10:   len <= len + LEN_W'(1);
        2'b01:   len <= len - LEN_W'(1);
        default: len <= len;
      endcase
    end
  end

  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      data_q <= '0;
    end else if (do_deq) begin
      data_q <= mem[head];
    end
  end

  // Set wins over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_evt | (overflow_q  & ~bus.clear_err_in);
      underflow_q <= udf_evt | (underflow_q & ~bus.clear_err_in);
    end
  end

  assign bus.data_out        = data_q;
  assign bus.len_out         = len;
  assign bus.full_out        = full;
  assign bus.empty_out       = empty;
  assign bus.almost_full_out = (len >= LEN_W'(AF_LEVEL));
  assign bus.overflow_out    = overflow_q;
  assign bus.underflow_out   = underflow_q;

endmodule

// File: tb/tb_fila_circular.sv
// Scoreboard bench: stimulus pushes expected outputs per edge, a negedge
// monitor pops and compares; two instances cover DEPTH=8 and DEPTH=5.
module tb_fila_circular;

  logic clk_10KHz = 1'b0;
  logic reset     = 1'b1;

  always #5 clk_10KHz = ~clk_10KHz;

  fila_circular_if #(.DATA_W(8), .DEPTH(8)) bus0 ();
  fila_circular_if #(.DATA_W(8), .DEPTH(5)) bus1 ();

  fila_circular #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6)) dut0 (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .bus       (bus0)
  );

  fila_circular #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4)) dut1 (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .bus       (bus1)
  );

  typedef struct {
    int dut;
    int dout;
    int len;
    int full;
    int empty;
    int af;
    int ovf;
    int udf;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: queue contents, last dequeued value, sticky flags.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  int m_dout[2];
  int m_ovf[2];
  int m_udf[2];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_10KHz) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.dut == 0) begin
        check("d0.data_out", int'(bus0.data_out), e.dout);
        check("d0.len_out", int'(bus0.len_out), e.len);
        check("d0.full_out", int'(bus0.full_out), e.full);
        check("d0.empty_out", int'(bus0.empty_out), e.empty);
        check("d0.almost_full_out", int'(bus0.almost_full_out), e.af);
        check("d0.overflow_out", int'(bus0.overflow_out), e.ovf);
        check("d0.underflow_out", int'(bus0.underflow_out), e.udf);
      end else begin
        check("d1.data_out", int'(bus1.data_out), e.dout);
        check("d1.len_out", int'(bus1.len_out), e.len);
        check("d1.full_out", int'(bus1.full_out), e.full);
        check("d1.empty_out", int'(bus1.empty_out), e.empty);
        check("d1.almost_full_out", int'(bus1.almost_full_out), e.af);
        check("d1.overflow_out", int'(bus1.overflow_out), e.ovf);
        check("d1.underflow_out", int'(bus1.underflow_out), e.udf);
      end
    end
  end

  function automatic exp_t snapshot(input int d, input int len);
    exp_t e;
    int depth;
    int af_level;
    depth    = (d == 0) ? 8 : 5;
    af_level = (d == 0) ? 6 : 4;
    e.dut   = d;
    e.dout  = m_dout[d];
    e.len   = len;
    e.full  = (len == depth) ? 1 : 0;
    e.empty = (len == 0) ? 1 : 0;
    e.af    = (len >= af_level) ? 1 : 0;
    e.ovf   = m_ovf[d];
    e.udf   = m_udf[d];
    return e;
  endfunction

  // One clock of stimulus on DUT d (the other idles), model update, and the
  // expectation pushed right after the edge for the negedge monitor.
  task automatic step(input bit rst, input int d, input bit enq, input bit deq,
                      input bit clr, input logic [7:0] data);
    logic [7:0] q[$];
    int depth;
    exp_t e0;
    exp_t e1;
    reset             = rst;
    bus0.enqueue_in   = (d == 0) ? enq : 1'b0;
    bus0.dequeue_in   = (d == 0) ? deq : 1'b0;
    bus0.clear_err_in = (d == 0) ? clr : 1'b0;
    bus0.data_in      = (d == 0) ? data : 8'h00;
    bus1.enqueue_in   = (d == 1) ? enq : 1'b0;
    bus1.dequeue_in   = (d == 1) ? deq : 1'b0;
    bus1.clear_err_in = (d == 1) ? clr : 1'b0;
    bus1.data_in      = (d == 1) ? data : 8'h00;

    if (rst) begin
      mq0.delete();
      mq1.delete();
      for (int i = 0; i < 2; i++) begin
        m_dout[i] = 0;
        m_ovf[i]  = 0;
        m_udf[i]  = 0;
      end
      e0 = snapshot(0, 0);
      e1 = snapshot(1, 0);
      @(posedge clk_10KHz);
      sb.push_back(e0);
      sb.push_back(e1);
    end else begin
      if (d == 0) q = mq0;
      else        q = mq1;
      depth = (d == 0) ? 8 : 5;
      if (clr) begin
        m_ovf[d] = 0;
        m_udf[d] = 0;
      end
      if (enq && deq) begin
        if (q.size() == 0) begin
          q.push_back(data);
          m_udf[d] = 1;
        end else begin
          m_dout[d] = int'(q.pop_front());
          q.push_back(data);
        end
      end else if (enq) begin
        if (q.size() == depth) m_ovf[d] = 1;
        else                   q.push_back(data);
      end else if (deq) begin
        if (q.size() == 0) m_udf[d] = 1;
        else               m_dout[d] = int'(q.pop_front());
      end
      e0 = snapshot(d, q.size());
      if (d == 0) mq0 = q;
      else        mq1 = q;
      @(posedge clk_10KHz);
      sb.push_back(e0);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    bus0.data_in = '0; bus0.enqueue_in = 0; bus0.dequeue_in = 0; bus0.clear_err_in = 0;
    bus1.data_in = '0; bus1.enqueue_in = 0; bus1.dequeue_in = 0; bus1.clear_err_in = 0;

    step(1, 0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 0, 8'h00);

    // 1: basic enqueue/dequeue order
    step(0, 0, 1, 0, 0, 8'h11);
    step(0, 0, 1, 0, 0, 8'h22);
    step(0, 0, 1, 0, 0, 8'h33);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 8'h00);

    // 2: fill past DEPTH, ninth value dropped
    for (int i = 1; i <= 9; i++) step(0, 0, 1, 0, 0, 8'(i));

    // 4: full queue, simultaneous enq+deq, then drain (0xAA last)
    step(0, 0, 1, 1, 0, 8'hAA);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 8'h00);

    // 3: underflow, clear-vs-set, clear
    step(0, 0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 1, 1, 8'h00);
    step(0, 0, 0, 0, 1, 8'h00);
    step(0, 0, 1, 1, 0, 8'h5C);
    step(0, 0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 0, 8'h00);

    // 5: DEPTH=5 bursts across pointer wrap
    v = 8'h40;
    for (int b = 0; b < 12; b++) begin
      if (b % 3 == 2) begin
        step(0, 1, 1, 1, 0, v);
        v = v + 8'h01;
      end else if (b % 2 == 0) begin
        for (int k = 0; k < 3; k++) begin
          step(0, 1, 1, 0, 0, v);
          v = v + 8'h01;
        end
      end else begin
        for (int k = 0; k < 2; k++) step(0, 1, 0, 1, 0, 8'h00);
      end
    end
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 0, 8'h00);

    // 6: reset mid-operation with enqueue asserted
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 8'(8'hE0 + i));
    step(0, 0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 0, 8'hE5);
    step(1, 0, 1, 0, 0, 8'hF0);
    step(0, 0, 0, 0, 0, 8'h00);

    @(negedge clk_10KHz);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
